// File: rtl/is_pkg.sv
// Shared definitions for the execution-unit scheduler.
// Function-unit bit positions in the issue/ready vectors and the
// address-unit FSM state encoding.
package is_pkg;

  localparam int unsigned NUM_FUN      = 4;
  localparam int unsigned FUN_MULT_BIT = 0;
  localparam int unsigned FUN_ADD1_BIT = 1;
  localparam int unsigned FUN_ADD2_BIT = 2;
  localparam int unsigned FUN_ADDR_BIT = 3;

  localparam int unsigned ADR_ST_W  = 2;
  localparam logic [ADR_ST_W-1:0] ADR_IDLE  = 2'd0;
  localparam logic [ADR_ST_W-1:0] ADR_REQ   = 2'd1;
  localparam logic [ADR_ST_W-1:0] ADR_WAIT  = 2'd2;
  localparam logic [ADR_ST_W-1:0] ADR_DRAIN = 2'd3;

  typedef enum logic [ADR_ST_W-1:0] {
    ST_IDLE  = ADR_IDLE,
    ST_REQ   = ADR_REQ,
    ST_WAIT  = ADR_WAIT,
    ST_DRAIN = ADR_DRAIN
  } adr_state_e;

endpackage

// File: rtl/exe_adr_fsm.sv
// Address-unit sequencer: issue -> memory request -> wait for ack.
// A flush abandons the op; if the memory already granted it, the FSM
// drains the outstanding ack without reporting completion.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   iss          accepted issue to the address unit
//   fls          ROB flush valid
//   mem_gnt      memory accepted the request
//   mem_ack      memory access complete
//   rdy          unit idle, may accept an issue
//   adr_mem_req  registered memory request, held until granted
//   adr_done     registered one-cycle completion pulse
module exe_adr_fsm
  import is_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic iss,
  input  logic fls,
  input  logic mem_gnt,
  input  logic mem_ack,
  output logic rdy,
  output logic adr_mem_req,
  output logic adr_done
);

  adr_state_e state;

  // State, request and completion are all updated together so the
  // request flop always mirrors the REQ state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      adr_mem_req <= 1'b0;
      adr_done    <= 1'b0;
    end else begin
      adr_mem_req <= 1'b0;
      adr_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iss && !fls) begin
            state       <= ST_REQ;
            adr_mem_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (fls) begin
            // A grant in the flush cycle leaves an ack still to come.
            state <= (mem_gnt && !mem_ack) ? ST_DRAIN : ST_IDLE;
          end else if (mem_gnt && mem_ack) begin
            state    <= ST_IDLE;
            adr_done <= 1'b1;
          end else if (mem_gnt) begin
            state <= ST_WAIT;
          end else begin
            adr_mem_req <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            state    <= ST_IDLE;
            adr_done <= !fls;
          end else if (fls) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (mem_ack) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rdy = (state == ST_IDLE);

endmodule

// File: rtl/exe_fun_sched.sv
// Execution-unit availability scheduler between issue and execution.
// Tracks mult/alu1/alu2/addr occupancy, sequences the non-pipelined
// multiplier, arbitrates the mult/alu2 shared writeback port and kills
// in-flight work on a ROB flush.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   iss_vld_frm_is  per-unit issue strobe (mult, alu1, alu2, addr)
//   fls_frm_rob     ROB flush; MSB is valid
//   mem_gnt/mem_ack memory handshake for the address unit
//   fun_rdy_to_is   per-unit ready back to issue
//   mul_wb_vld      mult result on shared writeback port
//   adr_mem_req     address-unit memory request
//   adr_done        address op completed
//   drop_err        sticky: issue seen on a busy unit
module exe_fun_sched
  import is_pkg::*;
#(
  parameter int unsigned BRN_WIDTH = 7,
  parameter int unsigned MUL_LAT   = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_FUN-1:0]   iss_vld_frm_is,
  input  logic [BRN_WIDTH-1:0] fls_frm_rob,
  input  logic                 mem_gnt,
  input  logic                 mem_ack,
  output logic [NUM_FUN-1:0]   fun_rdy_to_is,
  output logic                 mul_wb_vld,
  output logic                 adr_mem_req,
  output logic                 adr_done,
  output logic                 drop_err
);

  logic               up_q;
  logic [CNT_W-1:0]   mul_cnt;
  logic               fls;
  logic               adr_rdy;
  logic [NUM_FUN-1:0] iss_acc;
  logic               drop;
  logic               unused_fls_bits;

  assign fls             = fls_frm_rob[BRN_WIDTH-1];
  assign unused_fls_bits = ^fls_frm_rob[BRN_WIDTH-2:0];

  // Ready per unit; alu2 is held off when its writeback would collide
  // with the multiplier pulse one cycle later.
  always_comb begin
    fun_rdy_to_is = '0;
    if (up_q) begin
      fun_rdy_to_is[FUN_MULT_BIT] = (mul_cnt <= CNT_W'(1));
      fun_rdy_to_is[FUN_ADD1_BIT] = 1'b1;
      fun_rdy_to_is[FUN_ADD2_BIT] = (mul_cnt != CNT_W'(2));
      fun_rdy_to_is[FUN_ADDR_BIT] = adr_rdy;
    end
  end

  assign iss_acc    = iss_vld_frm_is & fun_rdy_to_is & {NUM_FUN{~fls}};
  assign drop       = (|(iss_vld_frm_is & ~fun_rdy_to_is)) & ~fls;
  assign mul_wb_vld = (mul_cnt == CNT_W'(1));

  // Power-up flag, sticky drop error and multiplier countdown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      up_q     <= 1'b0;
      drop_err <= 1'b0;
      mul_cnt  <= '0;
    end else begin
      up_q     <= 1'b1;
      drop_err <= drop_err | drop;
      if (fls) begin
        mul_cnt <= '0;
      end else if (iss_acc[FUN_MULT_BIT]) begin
        mul_cnt <= CNT_W'(MUL_LAT);
      end else if (mul_cnt != '0) begin
        mul_cnt <= mul_cnt - CNT_W'(1);
      end
    end
  end

  exe_adr_fsm u_adr_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss         (iss_acc[FUN_ADDR_BIT]),
    .fls         (fls),
    .mem_gnt     (mem_gnt),
    .mem_ack     (mem_ack),
    .rdy         (adr_rdy),
    .adr_mem_req (adr_mem_req),
    .adr_done    (adr_done)
  );

endmodule
